fifo_stream_adapter: RTL

- Read-side consumer stage for the synchronous FIFO.
- Drives the FIFO's r_en/empty/r_data port and re-presents the data as a valid/ready stream to downstream logic.
- Holds up to 3 words: one in-flight read plus a small prefetch buffer.
- Sustains 1 word/cycle with no combinational path from m_ready to fifo_r_en.

---
 rtl/fifo_stream_adapter.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//   Read-side consumer for a synchronous FIFO. It issues FIFO reads, captures the
//   returned words into a 3-entry ring and presents the head word as a valid/ready
//   stream. fifo_r_en depends only on registered state, fifo_empty, flush and the
//   reset, never on m_ready/m_valid. Three entries are enough to keep one word per
//   cycle flowing across the one-cycle FIFO read latency.
// Ports
//   clk, rst_n   : single rising-edge clock, asynchronous active-low reset
//   fifo_r_en    : FIFO read enable (out)
//   fifo_empty   : FIFO empty flag (in)
//   fifo_r_data  : FIFO read data, valid the cycle after fifo_r_en (in)
//   flush        : synchronous discard of buffered and in-flight words (in)
//   m_valid/m_ready/m_data : downstream stream
//   occupancy    : words held in the ring (0..3)
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_r_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       inflight_q, inflight_d;
  logic [2:0] reserved;
  logic       capture, pop;

  // Ring pointers step through 0,1,2 and wrap.
  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already committed: words held plus the word returning next cycle.
  assign reserved  = {1'b0, occ_q} + {2'b0, inflight_q};

  // rst_n gates the enable so no read is issued while reset is held, even though
  // the cleared state alone would otherwise allow one.
  assign fifo_r_en = rst_n && !fifo_empty && !flush && (reserved < 3'd3);

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf_q[head_q];
  assign occupancy = occ_q;

  // A word returning during a flush cycle belongs to the discarded stream.
  assign capture   = inflight_q && !flush;
  assign pop       = m_valid && m_ready;

  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_r_en;

    if (capture) begin
      buf_d[tail_q] = fifo_r_data;
      tail_d        = wrap_inc(tail_q);
    end
    if (pop) head_d = wrap_inc(head_q);

    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    // Flush empties the ring; a pop in the same cycle has already been seen by
    // the consumer, so only the pointers and count are reset.
    if (flush) begin
      head_d = 2'd0;
      tail_d = 2'd0;
      occ_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
